spi_slave_responder: RTL and testbench
======================================

Name: spi_slave_responder

Overview:
- Synthesizable single-lane SPI slave; the responder end of the SPI link driven by the master driver BFM.
- Oversamples sclk/cs_n/mosi on pclk, deserialises MOSI words to a parallel rx port, and serialises a host-supplied tx word onto MISO.
- Sits in hdl_top as the slave DUT-side model, or as a reusable slave in the RTL.

Parameters:
- DATA_WIDTH, 8, bits per SPI word (2..32).
- CPOL, 0, sclk idle level; leading edge = transition away from CPOL.
- CPHA, 0, 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.
- SYNC_STAGES, 2, synchroniser depth for sclk_i, cs_n_i, mosi_i (>=2).
- DEFAULT_FILL, all-ones, word sent on MISO when no tx data is buffered.

Ports:
- pclk  in  1  system clock, oversamples SPI (half sclk period >= SYNC_STAGES+2 pclk).
- areset  in  1  asynchronous reset, active-low.
- sclk_i  in  1  SPI clock from master.
- cs_n_i  in  1  chip select, active-low.
- mosi_i  in  1  master-out data.
- miso_o  out  1  slave-out data.
- miso_oe_o  out  1  MISO output enable (1 while selected).
- tx_data  in  DATA_WIDTH  next word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  tx holding register empty.
- rx_data  out  DATA_WIDTH  last received word.
- rx_valid  out  1  one-pclk pulse, rx_data updated.
- underrun  out  1  one-pclk pulse, DEFAULT_FILL loaded for lack of tx data.
- abort  out  1  one-pclk pulse, cs_n rose mid-word.

Behaviour:
- Reset (areset=0, async): miso_o=0, miso_oe_o=0, tx_ready=1, rx_data=0, rx_valid=0, underrun=0, abort=0, FSM=IDLE, bit counter=0, synchronisers preset to cs_n=1, sclk=CPOL, mosi=0.
- All SPI inputs pass through SYNC_STAGES flops; edges are detected by comparing the synchronised value with its one-cycle-delayed copy. All SPI timing below is in synchronised time.
- tx handshake: transfer when tx_valid && tx_ready on a pclk edge; tx_ready=0 the following cycle until the buffer is consumed. There is no bypass: a word accepted in the same cycle as a load is kept for the next word.
- FSM states:
  - IDLE: cs_n=1, miso_oe_o=0. On cs_n fall -> LOAD.
  - LOAD (1 cycle): the shift register takes tx_buf if full (tx_ready returns to 1), else DEFAULT_FILL with an underrun pulse. bitcnt=0. For CPHA=0 the MSB is placed on miso_o in this cycle. miso_oe_o=1. -> SHIFT.
  - SHIFT:
    - Sample edge: capture mosi into the rx shift register, bitcnt++.
    - Shift edge: present the next tx bit on miso_o. For CPHA=0 the trailing edge after the final sample is ignored. For CPHA=1 the first leading edge presents the MSB.
    - When bitcnt reaches DATA_WIDTH on a sample edge: rx_data is updated and rx_valid pulses on the next pclk, then -> LOAD while cs_n=0 (back-to-back words), else -> IDLE.
  - cs_n rise in SHIFT with 0<bitcnt<DATA_WIDTH: abort pulse, partial rx word discarded, rx_data unchanged, -> IDLE.
  - cs_n rise with bitcnt=0: -> IDLE with no pulse.
  - A shift register loaded with tx_buf is consumed even if aborted; tx_buf is not restored.
- Latency: rx_valid is asserted SYNC_STAGES+2 pclk after the final raw sampling sclk edge.
- Simultaneous events:
  - cs_n rise and sample edge in the same cycle: the cs_n rise wins, and the word completes only if this was bit DATA_WIDTH.
  - rx_valid fires even when a new LOAD happens the same cycle.
- No rx backpressure; rx_data is overwritten by the next completed word.

Optional Feature:
- Macro SPI_SLAVE_LSB_FIRST_EN.
- Defined: both tx and rx use LSB-first order; rx_data bit 0 is the first bit received.
- Undefined: MSB-first in both directions; the first bit received lands in rx_data[DATA_WIDTH-1].

Test Plan:
- Mode 0, one 8-bit transfer: host writes tx 0xA5 before cs_n falls; master sends MOSI 0x3C -> MISO carries 10100101, rx_data=0x3C, one rx_valid pulse, no underrun.
- Back-to-back words: cs_n held low for 16 sclks, tx 0x11 then 0x22 written, MOSI 0xF0,0x0F -> MISO 0x11,0x22; two rx_valid pulses with 0xF0 then 0x0F.
- Underrun: no tx write, 8-bit transfer -> MISO 0xFF, underrun pulses once in LOAD, rx still captured.
- Abort: cs_n rises after 5 sclks -> abort pulse, rx_valid not asserted, rx_data keeps its previous value, next transfer clean.
- CPHA=1, CPOL=1: tx 0x81, MOSI 0x7E -> rx_data=0x7E, MISO 10000001 with bits changing on falling sclk.
- Reset mid-word: areset low at bit 3 -> all outputs at reset values immediately; after release, cs_n still low does not start a word until cs_n goes high then low again.

Source files
------------

// File: rtl/spi_slave_responder.sv
// spi_slave_responder: oversampling SPI slave that deserialises MOSI to rx_data and serialises a buffered tx word onto MISO.
// Define SPI_SLAVE_LSB_FIRST_EN for LSB-first bit order in both directions (default MSB-first).
module spi_slave_responder #(
    parameter int                    DATA_WIDTH   = 8,
    parameter bit                    CPOL         = 1'b0,
    parameter bit                    CPHA         = 1'b0,
    parameter int                    SYNC_STAGES  = 2,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_FILL = '1
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic                  sclk_i,
    input  logic                  cs_n_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  underrun,
    output logic                  abort
);

`ifdef SPI_SLAVE_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif
    localparam int            CW       = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sclkSync, csSync, mosiSync, flushSync;
    logic                    sclkDly, csDly, armed, donePend;
    logic [CW-1:0]           bitCnt;
    logic [DATA_WIDTH-1:0]   txBuf, txShift, rxShift;

    logic sclkS, csS, mosiS;
    logic sclkRise, sclkFall, leadEdge, trailEdge, sampleEdge, shiftEdge;
    logic csFall, csRise;

    function automatic logic firstBit(input logic [DATA_WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shiftOut(input logic [DATA_WIDTH-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shiftIn(input logic [DATA_WIDTH-1:0] r, input logic b);
        return LSB_FIRST ? {b, r[DATA_WIDTH-1:1]} : {r[DATA_WIDTH-2:0], b};
    endfunction

    assign sclkS      = sclkSync[SYNC_STAGES-1];
    assign csS        = csSync[SYNC_STAGES-1];
    assign mosiS      = mosiSync[SYNC_STAGES-1];
    assign sclkRise   = sclkS & ~sclkDly;
    assign sclkFall   = ~sclkS & sclkDly;
    assign leadEdge   = CPOL ? sclkFall : sclkRise;
    assign trailEdge  = CPOL ? sclkRise : sclkFall;
    assign sampleEdge = CPHA ? trailEdge : leadEdge;
    assign shiftEdge  = CPHA ? leadEdge : trailEdge;
    assign csFall     = csDly & ~csS;
    assign csRise     = ~csDly & csS;

    // Synchronisers come out of reset with preset values, so a select that is already low
    // looks like a falling edge; armed only sets once a genuinely flushed cs_n has been seen high.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            sclkSync  <= {SYNC_STAGES{CPOL}};
            csSync    <= '1;
            mosiSync  <= '0;
            flushSync <= '0;
            sclkDly   <= CPOL;
            csDly     <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sclkSync  <= {sclkSync[SYNC_STAGES-2:0], sclk_i};
            csSync    <= {csSync[SYNC_STAGES-2:0], cs_n_i};
            mosiSync  <= {mosiSync[SYNC_STAGES-2:0], mosi_i};
            flushSync <= {flushSync[SYNC_STAGES-2:0], 1'b1};
            sclkDly   <= sclkS;
            csDly     <= csS;
            armed     <= armed | (flushSync[SYNC_STAGES-1] & csS);
        end
    end

    // Transfer FSM, tx holding register and rx publishing; rx_data is written one pclk after
    // the final sample so it can overlap the LOAD of a back-to-back word.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            state     <= IDLE;
            bitCnt    <= '0;
            txBuf     <= '0;
            txShift   <= '0;
            rxShift   <= '0;
            donePend  <= 1'b0;
            tx_ready  <= 1'b1;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            underrun  <= 1'b0;
            abort     <= 1'b0;
            miso_o    <= 1'b0;
            miso_oe_o <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            underrun <= 1'b0;
            abort    <= 1'b0;
            donePend <= 1'b0;

            if (donePend) begin
                rx_data  <= rxShift;
                rx_valid <= 1'b1;
            end

            if (tx_valid && tx_ready) begin
                txBuf    <= tx_data;
                tx_ready <= 1'b0;
            end

            case (state)
                IDLE: begin
                    miso_oe_o <= 1'b0;
                    miso_o    <= 1'b0;
                    if (csFall && armed)
                        state <= LOAD;
                end
                LOAD: begin
                    bitCnt <= '0;
                    if (!tx_ready) begin
                        txShift  <= txBuf;
                        tx_ready <= 1'b1;
                        if (!CPHA)
                            miso_o <= firstBit(txBuf);
                    end else begin
                        txShift  <= DEFAULT_FILL;
                        underrun <= 1'b1;
                        if (!CPHA)
                            miso_o <= firstBit(DEFAULT_FILL);
                    end
                    if (csRise) begin
                        state     <= IDLE;
                        miso_oe_o <= 1'b0;
                    end else begin
                        state     <= SHIFT;
                        miso_oe_o <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (sampleEdge) begin
                        rxShift <= shiftIn(rxShift, mosiS);
                        bitCnt  <= bitCnt + CW'(1);
                    end
                    // With CPHA=0 the trailing edge seen at bitCnt==0 belongs to the previous word.
                    if (shiftEdge) begin
                        if (bitCnt != '0) begin
                            txShift <= shiftOut(txShift);
                            miso_o  <= firstBit(shiftOut(txShift));
                        end else if (CPHA) begin
                            miso_o <= firstBit(txShift);
                        end
                    end
                    if (sampleEdge && bitCnt == LAST_BIT) begin
                        donePend <= 1'b1;
                        if (csS) begin
                            state     <= IDLE;
                            miso_oe_o <= 1'b0;
                        end else begin
                            state <= LOAD;
                        end
                    end else if (csRise) begin
                        abort     <= (bitCnt != '0);
                        state     <= IDLE;
                        miso_oe_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_responder.sv
// tb_spi_slave_responder: scoreboard bench driving a mode-0 and a mode-3 responder from an SPI master model.
// Expected rx words are queued at stimulus time and popped by a monitor on every rx_valid pulse.
module tb_spi_slave_responder;

    localparam int HALF = 8;
`ifdef SPI_SLAVE_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    logic       pclk   = 1'b0;
    logic       areset = 1'b0;
    logic       sclk0 = 1'b0, cs0 = 1'b1, mosi0 = 1'b0;
    logic       sclk3 = 1'b1, cs3 = 1'b1, mosi3 = 1'b0;
    logic       miso0, oe0, txReady0, rxValid0, underrun0, abort0, txValid0;
    logic       miso3, oe3, txReady3, rxValid3, underrun3, abort3, txValid3;
    logic [7:0] txData0, rxData0, txData3, rxData3;

    int tests = 0, failed = 0;
    int rxCnt0 = 0, urCnt0 = 0, abCnt0 = 0;
    int rxCnt3 = 0, urCnt3 = 0, abCnt3 = 0;
    logic [7:0] rxExp0[$];
    logic [7:0] rxExp3[$];

    logic [7:0] m0, m1;
    int         ur, rx, ab, urEnd;

    always #5 pclk = ~pclk;

    spi_slave_responder #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
        .pclk(pclk), .areset(areset), .sclk_i(sclk0), .cs_n_i(cs0), .mosi_i(mosi0),
        .miso_o(miso0), .miso_oe_o(oe0), .tx_data(txData0), .tx_valid(txValid0),
        .tx_ready(txReady0), .rx_data(rxData0), .rx_valid(rxValid0),
        .underrun(underrun0), .abort(abort0)
    );

    spi_slave_responder #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1)) dut3 (
        .pclk(pclk), .areset(areset), .sclk_i(sclk3), .cs_n_i(cs3), .mosi_i(mosi3),
        .miso_o(miso3), .miso_oe_o(oe3), .tx_data(txData3), .tx_valid(txValid3),
        .tx_ready(txReady3), .rx_data(rxData3), .rx_valid(rxValid3),
        .underrun(underrun3), .abort(abort3)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every rx_valid and tallies the status pulses.
    always @(negedge pclk) begin
        if (rxValid0 === 1'b1) begin
            rxCnt0++;
            if (rxExp0.size() == 0) checkOutput("rx0 unexpected word", 32'(rxExp0.size()), 1);
            else                    checkOutput("rx0 data", rxData0, rxExp0.pop_front());
        end
        if (rxValid3 === 1'b1) begin
            rxCnt3++;
            if (rxExp3.size() == 0) checkOutput("rx3 unexpected word", 32'(rxExp3.size()), 1);
            else                    checkOutput("rx3 data", rxData3, rxExp3.pop_front());
        end
        if (underrun0 === 1'b1) urCnt0++;
        if (underrun3 === 1'b1) urCnt3++;
        if (abort0 === 1'b1)    abCnt0++;
        if (abort3 === 1'b1)    abCnt3++;
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic bitOf(input logic [7:0] w, input int b);
        return LSB_FIRST ? w[b] : w[7-b];
    endfunction

    function automatic logic [7:0] shiftIn(input logic [7:0] g, input logic b);
        return LSB_FIRST ? {b, g[7:1]} : {g[6:0], b};
    endfunction

    task automatic waitHalf();
        repeat (HALF) @(negedge pclk);
    endtask

    task automatic setSclk(input bit sel, input logic v);
        if (sel) sclk3 = v; else sclk0 = v;
    endtask

    task automatic setCs(input bit sel, input logic v);
        if (sel) cs3 = v; else cs0 = v;
    endtask

    task automatic setMosi(input bit sel, input logic v);
        if (sel) mosi3 = v; else mosi0 = v;
    endtask

    task automatic hostWrite(input bit sel, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge pclk);
        while (!(sel ? txReady3 : txReady0) && n < 2000) begin
            @(negedge pclk);
            n++;
        end
        if (n >= 2000) checkOutput("tx_ready timeout", sel ? txReady3 : txReady0, 1);
        if (sel) begin txData3 = d; txValid3 = 1'b1; end
        else     begin txData0 = d; txValid0 = 1'b1; end
        @(negedge pclk);
        if (sel) txValid3 = 1'b0; else txValid0 = 1'b0;
    endtask

    // Master model: sel=0 drives mode 0 (dut0), sel=1 drives mode 3 (dut3); stopAfter>0 raises cs early.
    task automatic applyStimulus(input bit sel, input int nWords, input logic [7:0] w0,
                                 input logic [7:0] w1, input int stopAfter,
                                 output logic [7:0] g0, output logic [7:0] g1, output int urSnap);
        logic [7:0] words [2];
        logic [7:0] got [2];
        logic       cpol;
        int         total, w, b;
        cpol     = sel;
        words[0] = w0;
        words[1] = w1;
        got[0]   = '0;
        got[1]   = '0;
        urSnap   = sel ? urCnt3 : urCnt0;
        total    = (stopAfter > 0) ? stopAfter : nWords * 8;
        if (!sel) setMosi(sel, bitOf(w0, 0));
        setCs(sel, 1'b0);
        waitHalf();
        for (int k = 0; k < total; k++) begin
            w = k / 8;
            b = k % 8;
            if (!sel) begin
                setSclk(sel, ~cpol);
                got[w] = shiftIn(got[w], miso0);
                if (k == total - 1) urSnap = urCnt0;
                waitHalf();
                setSclk(sel, cpol);
                if (k + 1 < total) setMosi(sel, bitOf(words[(k+1)/8], (k+1) % 8));
                waitHalf();
            end else begin
                setSclk(sel, ~cpol);
                setMosi(sel, bitOf(words[w], b));
                waitHalf();
                setSclk(sel, cpol);
                got[w] = shiftIn(got[w], miso3);
                if (k == total - 1) urSnap = urCnt3;
                waitHalf();
            end
        end
        setCs(sel, 1'b1);
        waitHalf();
        waitHalf();
        g0 = got[0];
        g1 = got[1];
    endtask

    initial begin
        txValid0 = 1'b0; txData0 = '0;
        txValid3 = 1'b0; txData3 = '0;
        repeat (3) @(negedge pclk);
        checkOutput("reset miso_o", miso0, 0);
        checkOutput("reset miso_oe_o", oe0, 0);
        checkOutput("reset tx_ready", txReady0, 1);
        checkOutput("reset rx_data", rxData0, 0);
        checkOutput("reset rx_valid", rxValid0, 0);
        checkOutput("reset underrun", underrun0, 0);
        checkOutput("reset abort", abort0, 0);
        checkOutput("reset mode3 miso_oe_o", oe3, 0);
        areset = 1'b1;
        repeat (6) @(negedge pclk);

        // Mode 0 single word
        ur = urCnt0; rx = rxCnt0;
        hostWrite(0, 8'hA5);
        rxExp0.push_back(8'h3C);
        applyStimulus(0, 1, 8'h3C, 8'h00, 0, m0, m1, urEnd);
        checkOutput("mode0 miso word", m0, 8'hA5);
        checkOutput("mode0 rx_valid count", rxCnt0 - rx, 1);
        checkOutput("mode0 underrun count", urEnd - ur, 0);

        // Back-to-back words with the second tx write during the first word
        ur = urCnt0; rx = rxCnt0;
        hostWrite(0, 8'h11);
        rxExp0.push_back(8'hF0);
        rxExp0.push_back(8'h0F);
        fork
            applyStimulus(0, 2, 8'hF0, 8'h0F, 0, m0, m1, urEnd);
            hostWrite(0, 8'h22);
        join
        checkOutput("b2b miso word 1", m0, 8'h11);
        checkOutput("b2b miso word 2", m1, 8'h22);
        checkOutput("b2b rx_valid count", rxCnt0 - rx, 2);
        checkOutput("b2b underrun count", urEnd - ur, 0);

        // Underrun: nothing buffered
        ur = urCnt0; rx = rxCnt0;
        rxExp0.push_back(8'h5A);
        applyStimulus(0, 1, 8'h5A, 8'h00, 0, m0, m1, urEnd);
        checkOutput("underrun miso word", m0, 8'hFF);
        checkOutput("underrun pulse count", urEnd - ur, 1);
        checkOutput("underrun rx_valid count", rxCnt0 - rx, 1);

        // Abort after 5 bits
        ab = abCnt0; rx = rxCnt0;
        hostWrite(0, 8'h77);
        applyStimulus(0, 1, 8'hAA, 8'h00, 5, m0, m1, urEnd);
        checkOutput("abort pulse count", abCnt0 - ab, 1);
        checkOutput("abort rx_valid count", rxCnt0 - rx, 0);
        checkOutput("abort rx_data kept", rxData0, 8'h5A);
        checkOutput("abort tx consumed", txReady0, 1);

        // Clean transfer after the abort
        ab = abCnt0; rx = rxCnt0;
        hostWrite(0, 8'hC3);
        rxExp0.push_back(8'h96);
        applyStimulus(0, 1, 8'h96, 8'h00, 0, m0, m1, urEnd);
        checkOutput("post-abort miso word", m0, 8'hC3);
        checkOutput("post-abort rx_valid count", rxCnt0 - rx, 1);
        checkOutput("post-abort abort count", abCnt0 - ab, 0);

        // Mode 3 (CPOL=1, CPHA=1)
        ur = urCnt3; rx = rxCnt3;
        hostWrite(1, 8'h81);
        rxExp3.push_back(8'h7E);
        applyStimulus(1, 1, 8'h7E, 8'h00, 0, m0, m1, urEnd);
        checkOutput("mode3 miso word", m0, 8'h81);
        checkOutput("mode3 rx_valid count", rxCnt3 - rx, 1);
        checkOutput("mode3 underrun count", urEnd - ur, 0);

        // Reset in the middle of a word
        setMosi(0, 1'b1);
        setCs(0, 1'b0);
        waitHalf();
        repeat (3) begin
            setSclk(0, 1'b1); waitHalf();
            setSclk(0, 1'b0); waitHalf();
        end
        #2 areset = 1'b0;
        #1;
        checkOutput("midreset miso_oe_o", oe0, 0);
        checkOutput("midreset miso_o", miso0, 0);
        checkOutput("midreset tx_ready", txReady0, 1);
        checkOutput("midreset rx_data", rxData0, 0);
        repeat (4) @(negedge pclk);
        areset = 1'b1;
        ur = urCnt0; rx = rxCnt0;
        repeat (8) begin
            setSclk(0, 1'b1); waitHalf();
            setSclk(0, 1'b0); waitHalf();
        end
        checkOutput("held cs no start oe", oe0, 0);
        checkOutput("held cs no load", urCnt0 - ur, 0);
        checkOutput("held cs no rx", rxCnt0 - rx, 0);
        setCs(0, 1'b1);
        waitHalf();
        waitHalf();
        rx = rxCnt0;
        hostWrite(0, 8'h5C);
        rxExp0.push_back(8'hE1);
        applyStimulus(0, 1, 8'hE1, 8'h00, 0, m0, m1, urEnd);
        checkOutput("post-reset miso word", m0, 8'h5C);
        checkOutput("post-reset rx_valid count", rxCnt0 - rx, 1);

        repeat (10) @(negedge pclk);
        checkOutput("rx0 scoreboard drained", 32'(rxExp0.size()), 0);
        checkOutput("rx3 scoreboard drained", 32'(rxExp3.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
